// File: rtl/ex_stage_pkg.sv
// Shared decode constants for the execute stage: aluop/alusel codes, bundle
// defaults and the divider state encoding.
package ex_stage_pkg;

  localparam int ALUOP_W   = 8;
  localparam int ALUSEL_W  = 3;
  localparam int REG_ADDR_W = 5;

  localparam logic [31:0]           ZeroWord     = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOPRegAddr   = 5'b00000;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic                  RstEnable    = 1'b1;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALUOP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALUSEL_W-1:0] EXE_RES_DIV   = 3'b101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider (one quotient bit per cycle) with signed fix-up
// and a stall request that covers the whole operation.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);

  div_state_e        r_state;
  div_state_e        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_divisor;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_last;

  assign w_a_neg = i_signed & i_dividend[DATA_W-1];
  assign w_b_neg = i_signed & i_divisor[DATA_W-1];
  assign w_abs_a = w_a_neg ? -i_dividend : i_dividend;
  assign w_abs_b = w_b_neg ? -i_divisor  : i_divisor;

  // The quotient register starts as |A| and shifts its MSB into the remainder.
  assign w_rem_sh = {r_rem, r_quot[DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  // NOTE: only the FSM and counter are reset; the datapath is always reloaded
  // on start, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (resetn == RstEnable) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            r_cnt <= '0;
            if (i_divisor == '0) begin
              r_quot  <= '1;
              r_rem   <= i_dividend;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_quot    <= w_abs_a;
              r_rem     <= '0;
              r_divisor <= w_abs_b;
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
            end
          end
        end
        DIV_ON: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_diff[DATA_W]) begin
            r_rem  <= w_diff[DATA_W-1:0];
            r_quot <= {r_quot[DATA_W-2:0], 1'b1};
          end else begin
            r_rem  <= w_rem_sh[DATA_W-1:0];
            r_quot <= {r_quot[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next  = r_state;
    o_stall = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (i_start) begin
          o_stall = 1'b1;
          w_next  = (i_divisor == '0) ? DIV_ZERO : DIV_ON;
        end
      end
      DIV_ON: begin
        o_stall = 1'b1;
        if (w_last) w_next = DIV_END;
      end
      DIV_ZERO: begin
        o_stall = 1'b1;
        w_next  = DIV_END;
      end
      DIV_END: begin
        o_valid = 1'b1;
        w_next  = DIV_IDLE;
      end
    endcase
  end

  assign o_quot = r_neg_q ? -r_quot : r_quot;
  assign o_rem  = r_neg_r ? -r_rem  : r_rem;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU mux plus the iterative divider.
// Optional feature: define EX_MUL_EN to add MUL/MULT/MULTU.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ALUOP_W-1:0]    ex_aluop_i,
  input  logic [ALUSEL_W-1:0]   ex_alusel_i,
  input  logic [DATA_W-1:0]     ex_reg1_i,
  input  logic [DATA_W-1:0]     ex_reg2_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  output logic [REG_ADDR_W-1:0] ex_wd_o,
  output logic                  ex_wreg_o,
  output logic [DATA_W-1:0]     ex_wdata_o,
  output logic                  ex_whilo_o,
  output logic [DATA_W-1:0]     ex_hi_o,
  output logic [DATA_W-1:0]     ex_lo_o,
  output logic                  stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_logic;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_arith;
  logic              w_is_div;
  logic              w_div_valid;
  logic [DATA_W-1:0] w_div_quot;
  logic [DATA_W-1:0] w_div_rem;

  assign w_sh     = ex_reg2_i[SH_W-1:0];
  assign w_is_div = (ex_aluop_i == EXE_DIV_OP) || (ex_aluop_i == EXE_DIVU_OP);

`ifdef EX_MUL_EN
  logic [2*DATA_W-1:0] w_prod_s;
  logic [2*DATA_W-1:0] w_prod_u;
  assign w_prod_s = {{DATA_W{ex_reg1_i[DATA_W-1]}}, ex_reg1_i} *
                    {{DATA_W{ex_reg2_i[DATA_W-1]}}, ex_reg2_i};
  assign w_prod_u = {{DATA_W{1'b0}}, ex_reg1_i} * {{DATA_W{1'b0}}, ex_reg2_i};
`endif

  always_comb begin
    w_logic = '0;
    case (ex_aluop_i)
      EXE_AND_OP: w_logic = ex_reg1_i & ex_reg2_i;
      EXE_OR_OP:  w_logic = ex_reg1_i | ex_reg2_i;
      EXE_XOR_OP: w_logic = ex_reg1_i ^ ex_reg2_i;
      EXE_NOR_OP: w_logic = ~(ex_reg1_i | ex_reg2_i);
      default:    w_logic = '0;
    endcase
  end

  always_comb begin
    w_shift = '0;
    case (ex_aluop_i)
      EXE_SLL_OP: w_shift = ex_reg1_i << w_sh;
      EXE_SRL_OP: w_shift = ex_reg1_i >> w_sh;
      EXE_SRA_OP: w_shift = $signed(ex_reg1_i) >>> w_sh;
      default:    w_shift = '0;
    endcase
  end

  always_comb begin
    w_arith = '0;
    case (ex_aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP: w_arith = ex_reg1_i + ex_reg2_i;
      EXE_SUB_OP, EXE_SUBU_OP: w_arith = ex_reg1_i - ex_reg2_i;
      EXE_SLT_OP:  w_arith = {{(DATA_W-1){1'b0}}, $signed(ex_reg1_i) < $signed(ex_reg2_i)};
      EXE_SLTU_OP: w_arith = {{(DATA_W-1){1'b0}}, ex_reg1_i < ex_reg2_i};
`ifdef EX_MUL_EN
      EXE_MUL_OP:  w_arith = w_prod_s[DATA_W-1:0];
`endif
      default:     w_arith = '0;
    endcase
  end

  always_comb begin
    ex_wdata_o = '0;
    case (ex_alusel_i)
      EXE_RES_LOGIC: ex_wdata_o = w_logic;
      EXE_RES_SHIFT: ex_wdata_o = w_shift;
      EXE_RES_ARITH: ex_wdata_o = w_arith;
      default:       ex_wdata_o = '0;
    endcase
  end

  always_comb begin
    ex_whilo_o = 1'b0;
    ex_hi_o    = '0;
    ex_lo_o    = '0;
    if (w_div_valid) begin
      ex_whilo_o = 1'b1;
      ex_hi_o    = w_div_rem;
      ex_lo_o    = w_div_quot;
    end
`ifdef EX_MUL_EN
    else if (ex_aluop_i == EXE_MULT_OP) begin
      ex_whilo_o         = 1'b1;
      {ex_hi_o, ex_lo_o} = w_prod_s;
    end else if (ex_aluop_i == EXE_MULTU_OP) begin
      ex_whilo_o         = 1'b1;
      {ex_hi_o, ex_lo_o} = w_prod_u;
    end
`endif
  end

  ex_div #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_is_div),
    .i_signed   (ex_aluop_i == EXE_DIV_OP),
    .i_dividend (ex_reg1_i),
    .i_divisor  (ex_reg2_i),
    .o_stall    (stallreq_o),
    .o_valid    (w_div_valid),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );

  // A stalled instruction must not retire into the register file.
  assign ex_wd_o   = ex_wd_i;
  assign ex_wreg_o = stallreq_o ? WriteDisable : ex_wreg_i;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Consumes the registered ID/EX bundle (aluop, alusel, two operands, destination, write-enable) and produces the write-back bundle for the EX/MEM register.
- Single-cycle ops (logic, shift, add/sub, slt) are combinational from the inputs.
- DIV/DIVU run on an iterative 32-step divider FSM. The FSM raises a stall request back to pipeline control, which holds ID/EX stable until the result is ready.

Parameters:
- DATA_W, 32, operand/result width; the divider iteration count equals DATA_W.
- CNT_W, 6, width of the divider step counter; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous reset, active-high (1 = reset). Only resets the divider FSM state.
- ex_aluop_i  in  8  operation code.
- ex_alusel_i  in  3  result class: NOP, LOGIC, SHIFT, ARITH, DIV.
- ex_reg1_i  in  32  operand A (rs, or dividend).
- ex_reg2_i  in  32  operand B (rt/imm, or divisor; shift amount is taken from [4:0]).
- ex_wd_i  in  5  destination register.
- ex_wreg_i  in  1  register write-enable.
- ex_wd_o  out  5  destination, passthrough.
- ex_wreg_o  out  1  write-enable; forced to 0 while stallreq_o = 1.
- ex_wdata_o  out  32  GPR result.
- ex_whilo_o  out  1  HI/LO write strobe.
- ex_hi_o  out  32  remainder.
- ex_lo_o  out  32  quotient.
- stallreq_o  out  1  asserted when the pipeline must hold ID/EX and younger stages.

Behaviour:
- Outputs are combinational from the inputs and FSM state.
- After reset, FSM = IDLE. With NOP inputs, all outputs are 0.
- Single-cycle ops, result class by alusel:
  - LOGIC: AND, OR, XOR, NOR.
  - SHIFT: SLL, SRL, SRA by reg2[4:0].
  - ARITH: ADD/SUB modulo 2^32 with no overflow trap; SLT signed, SLTU unsigned, result 0 or 1.
  - Undefined aluop: ex_wdata_o = 0.
  - ex_whilo_o = 0 for all single-cycle ops.
- Divider FSM states: IDLE, DIV_ON, DIV_ZERO, DIV_END.
- IDLE:
  - Non-DIV op: no action.
  - DIV op with ex_reg2_i = 0: go to DIV_ZERO.
  - DIV op otherwise: latch |A|, |B| (raw values for DIVU), and the quotient/remainder signs; clear the counter; go to DIV_ON.
  - stallreq_o = 1 in the same cycle a DIV op is first seen.
- DIV_ON: one restoring shift-subtract step per cycle; counter increments; after DATA_W steps (counter = 31 step taken), go to DIV_END. stallreq_o = 1.
- DIV_ZERO: one cycle, stallreq_o = 1, then DIV_END with quotient = 0xFFFFFFFF and remainder = dividend.
- DIV_END:
  - stallreq_o = 0; ex_whilo_o = 1; ex_lo_o = quotient; ex_hi_o = remainder.
  - Signed fix-up: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Next state is IDLE unconditionally, even if the same DIV is still presented. The pipeline advances on this edge.
- Latency: a nonzero DIV holds stallreq_o for 33 cycles; the result appears in cycle 34. A divide-by-zero holds stallreq_o for 2 cycles.
- Operand changes while in DIV_ON are ignored; the latched copies are used.
- resetn = 1 in any state: next state IDLE, counter 0, partial result discarded, stallreq_o drops the cycle after the reset edge.
- A 0x80000000 / -1 signed divide yields quotient 0x80000000, remainder 0 (wraps).

Optional Feature:
- EX_MUL_EN
  - Defined: aluop MUL gives ex_wdata_o = low 32 bits of the signed product; MULT/MULTU write the 64-bit product to HI/LO with ex_whilo_o = 1. All are single-cycle with no stall.
  - Undefined: these aluops decode as undefined (wdata 0, whilo 0), and no multiplier is synthesized.

Decomposition:
- Shared package/header: aluop codes (EXE_*_OP), alusel codes (EXE_RES_*), ZeroWord, NOPRegAddr, WriteEnable/Disable, RstEnable, divider state encodings. The same codes are used by the decoder and ID_EX.
- One sub-module, ex_div: owns the FSM, counter, sign handling and the stall/ready interface. The ALU mux stays in ex_stage.

Test Plan:
- ARITH ADD with A = 5, B = 7, wd = 3, wreg = 1 -> wdata = 12, wd_o = 3, wreg_o = 1, stallreq = 0, whilo = 0.
- DIVU with A = 100, B = 7, held stable -> stallreq = 1 for exactly 33 cycles; then lo = 14, hi = 2, whilo = 1 for one cycle; FSM returns to IDLE.
- DIV with A = 0xFFFFFF9C (-100), B = 7 -> lo = 0xFFFFFFF2 (-14), hi = 0xFFFFFFFE (-2).
- DIV with A = 0x1234, B = 0 -> stallreq for 2 cycles; lo = 0xFFFFFFFF, hi = 0x1234.
- DIVU started, resetn = 1 at step 10 -> IDLE next cycle, stallreq = 0, whilo never pulses.
- SRA with A = 0x80000000, B = 4 -> wdata = 0xF8000000. Then SLT with A = -1, B = 1 -> wdata = 1; SLTU with the same operands -> wdata = 0.
